// File: rtl/acq_wnd_seqgen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : acq_wnd_seqgen_pkg
// Brief   : Shared widths and one-hot state encoding for the acquisition
//           window sequence generator.
// Rev     : 1.0  initial release
// ============================================================================
package acq_wnd_seqgen_pkg;

  localparam int c_DEF_DELAY_WIDTH    = 32;
  localparam int c_DEF_ECHO_CNT_WIDTH = 32;

  // One-hot sequencer states
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_DELAY = 5'b00010,
    S_WND   = 5'b00100,
    S_GAP   = 5'b01000,
    S_FIN   = 5'b10000
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/acq_wnd_seqgen_if.sv
`default_nettype none
// ============================================================================
// Module  : acq_wnd_seqgen_if
// Brief   : Config/control and window outputs of the echo-train sequencer.
// Config  : ACQ_WND_DUMMY_ECHO_EN adds the DUMMY_ECHOES input.
// Rev     : 1.0  initial release
// ============================================================================
interface acq_wnd_seqgen_if
  import acq_wnd_seqgen_pkg::*;
#(
  parameter int DELAY_WIDTH    = c_DEF_DELAY_WIDTH,
  parameter int ECHO_CNT_WIDTH = c_DEF_ECHO_CNT_WIDTH
);
  logic                      START;
  logic [DELAY_WIDTH-1:0]    FIRST_DELAY;
  logic [DELAY_WIDTH-1:0]    ECHO_PERIOD;
  logic [DELAY_WIDTH-1:0]    WND_LEN;
  logic [ECHO_CNT_WIDTH-1:0] NUM_ECHOES;
`ifdef ACQ_WND_DUMMY_ECHO_EN
  logic [ECHO_CNT_WIDTH-1:0] DUMMY_ECHOES;
`endif
  logic                      ACQ_WND;
  logic [ECHO_CNT_WIDTH-1:0] ECHO_IDX;
  logic                      BUSY;
  logic                      DONE;

  modport master (
    output START, FIRST_DELAY, ECHO_PERIOD, WND_LEN, NUM_ECHOES,
`ifdef ACQ_WND_DUMMY_ECHO_EN
    output DUMMY_ECHOES,
`endif
    input  ACQ_WND, ECHO_IDX, BUSY, DONE
  );

  modport slave (
    input  START, FIRST_DELAY, ECHO_PERIOD, WND_LEN, NUM_ECHOES,
`ifdef ACQ_WND_DUMMY_ECHO_EN
    input  DUMMY_ECHOES,
`endif
    output ACQ_WND, ECHO_IDX, BUSY, DONE
  );
endinterface
`default_nettype wire

// File: rtl/acq_wnd_seqgen_wnd_down_counter.sv
`default_nettype none
// ============================================================================
// Module  : wnd_down_counter
// Brief   : Loadable down-counter that holds at zero; zero flag is the
//           terminal-count indication used by the sequencer timers.
// Rev     : 1.0  initial release
// ============================================================================
module wnd_down_counter #(
  parameter int WIDTH = 32
) (
  input  wire logic             CLK,
  input  wire logic             RESET,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  output logic                  o_zero
);
  localparam logic [WIDTH-1:0] c_ONE = 1;

  logic [WIDTH-1:0] r_count;

  // Load has priority; otherwise count down and park at zero
  always_ff @(posedge CLK) begin
    if (RESET)
      r_count <= '0;
    else if (i_load)
      r_count <= i_load_val;
    else if (r_count != '0)
      r_count <= r_count - c_ONE;
  end

  assign o_zero = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/acq_wnd_seqgen.sv
`default_nettype none
// ============================================================================
// Module  : acq_wnd_seqgen
// Brief   : Generates a train of acquisition windows: first rise FIRST_DELAY
//           cycles after START, then one window per ECHO_PERIOD, each WND_LEN
//           cycles high. All outputs are flops.
// Config  : ACQ_WND_DUMMY_ECHO_EN - leading DUMMY_ECHOES slots run their
//           timing and index but keep ACQ_WND low.
// Rev     : 1.0  initial release
// ============================================================================
module acq_wnd_seqgen
  import acq_wnd_seqgen_pkg::*;
#(
  parameter int DELAY_WIDTH    = c_DEF_DELAY_WIDTH,
  parameter int ECHO_CNT_WIDTH = c_DEF_ECHO_CNT_WIDTH
) (
  input  wire logic       CLK,
  input  wire logic       RESET,
  acq_wnd_seqgen_if.slave bus
);
`ifdef ACQ_WND_DUMMY_ECHO_EN
  localparam int c_SLOT_W = ECHO_CNT_WIDTH + 1;  // dummy + real may carry
`else
  localparam int c_SLOT_W = ECHO_CNT_WIDTH;
`endif
  localparam logic [DELAY_WIDTH-1:0]    c_D_ONE = 1;
  localparam logic [ECHO_CNT_WIDTH-1:0] c_E_ONE = 1;
  localparam logic [c_SLOT_W-1:0]       c_S_ONE = 1;

  seq_state_t                r_state, w_state_nxt;
  logic [DELAY_WIDTH-1:0]    r_per_m1, r_wl_m1;
  logic [c_SLOT_W-1:0]       r_slots_left;
  logic [ECHO_CNT_WIDTH-1:0] r_echo_idx;
  logic                      r_first, r_slot_dummy;
  logic                      r_acq_wnd, r_busy, r_done;
`ifdef ACQ_WND_DUMMY_ECHO_EN
  logic [ECHO_CNT_WIDTH-1:0] r_dummy_left;
`endif
  logic                      w_dummy_now;
  logic                      w_accept, w_rise;
  logic                      w_per_load, w_wnd_load, w_per_zero, w_wnd_zero;
  logic [DELAY_WIDTH-1:0]    w_per_load_val;
  logic [DELAY_WIDTH-1:0]    w_fd_m1, w_wl_eff, w_wl_m1, w_per_m1;
  logic [c_SLOT_W-1:0]       w_total_slots;
  logic                      w_acq_nxt, w_busy_nxt, w_done_nxt;

  // Effective config from the live inputs; only captured on acceptance.
  // Timers hold value-1 so a load at edge t reaches zero at edge t+value.
  always_comb begin
    w_fd_m1  = (bus.FIRST_DELAY == '0) ? '0 : bus.FIRST_DELAY - c_D_ONE;
    w_wl_eff = (bus.WND_LEN == '0) ? c_D_ONE : bus.WND_LEN;
    w_wl_m1  = w_wl_eff - c_D_ONE;
    // period-1 = max(P-1, WL_eff) avoids overflow of WL_eff+1
    w_per_m1 = (bus.ECHO_PERIOD > w_wl_eff) ? bus.ECHO_PERIOD - c_D_ONE : w_wl_eff;
`ifdef ACQ_WND_DUMMY_ECHO_EN
    w_total_slots = {1'b0, bus.NUM_ECHOES} + {1'b0, bus.DUMMY_ECHOES};
`else
    w_total_slots = bus.NUM_ECHOES;
`endif
  end

`ifdef ACQ_WND_DUMMY_ECHO_EN
  assign w_dummy_now = (r_dummy_left != '0);
`else
  assign w_dummy_now = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RESET)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state, timer control and next registered outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_rise         = 1'b0;
    w_per_load     = 1'b0;
    w_per_load_val = r_per_m1;
    w_wnd_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.START) begin
          w_accept       = 1'b1;
          w_state_nxt    = S_DELAY;
          w_per_load     = 1'b1;
          w_per_load_val = w_fd_m1;
        end
      end
      S_DELAY, S_GAP: begin
        if (r_slots_left == '0) begin
          w_state_nxt = S_FIN;
        end else if (w_per_zero) begin
          w_rise      = 1'b1;
          w_state_nxt = S_WND;
          w_per_load  = 1'b1;
          w_wnd_load  = 1'b1;
        end
      end
      S_WND: begin
        if (w_wnd_zero)
          w_state_nxt = S_GAP;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_acq_nxt = 1'b0;
    if (w_rise)
      w_acq_nxt = !w_dummy_now;
    else if ((r_state == S_WND) && (w_state_nxt == S_WND))
      w_acq_nxt = !r_slot_dummy;
    w_busy_nxt = (w_state_nxt == S_DELAY) || (w_state_nxt == S_WND) ||
                 (w_state_nxt == S_GAP);
    w_done_nxt = (w_state_nxt == S_FIN);
  end

  // Latched config, slot bookkeeping and output flops
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_per_m1     <= '0;
      r_wl_m1      <= '0;
      r_slots_left <= '0;
      r_echo_idx   <= '0;
      r_first      <= 1'b0;
      r_slot_dummy <= 1'b0;
      r_acq_wnd    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef ACQ_WND_DUMMY_ECHO_EN
      r_dummy_left <= '0;
`endif
    end else begin
      r_acq_wnd <= w_acq_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      if (w_accept) begin
        r_per_m1     <= w_per_m1;
        r_wl_m1      <= w_wl_m1;
        r_slots_left <= w_total_slots;
        r_echo_idx   <= '0;
        r_first      <= 1'b1;
        r_slot_dummy <= 1'b0;
`ifdef ACQ_WND_DUMMY_ECHO_EN
        r_dummy_left <= bus.DUMMY_ECHOES;
`endif
      end else if (w_rise) begin
        r_slots_left <= r_slots_left - c_S_ONE;
        r_first      <= 1'b0;
        r_slot_dummy <= w_dummy_now;
        if (!r_first)
          r_echo_idx <= r_echo_idx + c_E_ONE;
`ifdef ACQ_WND_DUMMY_ECHO_EN
        if (w_dummy_now)
          r_dummy_left <= r_dummy_left - c_E_ONE;
`endif
      end
    end
  end

  wnd_down_counter #(.WIDTH(DELAY_WIDTH)) u_per_tmr (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_load     (w_per_load),
    .i_load_val (w_per_load_val),
    .o_zero     (w_per_zero)
  );

  wnd_down_counter #(.WIDTH(DELAY_WIDTH)) u_wnd_tmr (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_load     (w_wnd_load),
    .i_load_val (r_wl_m1),
    .o_zero     (w_wnd_zero)
  );

  assign bus.ACQ_WND  = r_acq_wnd;
  assign bus.ECHO_IDX = r_echo_idx;
  assign bus.BUSY     = r_busy;
  assign bus.DONE     = r_done;
endmodule
`default_nettype wire

// File: doc/acq_wnd_seqgen.md
ACQ_WND_SEQGEN -- requirements
Module: acq_wnd_seqgen

Interface
REQ-001 Parameter DELAY_WIDTH, default 32, width of all cycle-count inputs.
REQ-002 Parameter ECHO_CNT_WIDTH, default 32, width of echo count and index.
REQ-003 CLK  input  1  system clock; single clock domain.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 START  input  1  level; a high sample in IDLE starts one echo train.
REQ-006 FIRST_DELAY  input  DELAY_WIDTH  cycles from START sample to first ACQ_WND rise; minimum 1.
REQ-007 ECHO_PERIOD  input  DELAY_WIDTH  cycles between consecutive ACQ_WND rising edges.
REQ-008 WND_LEN  input  DELAY_WIDTH  cycles ACQ_WND is high per echo; minimum 1.
REQ-009 NUM_ECHOES  input  ECHO_CNT_WIDTH  windows per train.
REQ-010 ACQ_WND  output  1  acquisition window to the ADC window generator (downstream detects rising edge).
REQ-011 ECHO_IDX  output  ECHO_CNT_WIDTH  zero-based index of the current or most recent window.
REQ-012 BUSY  output  1  high from START acceptance until DONE.
REQ-013 DONE  output  1  one-cycle pulse at train end.

Function
REQ-014 States SHALL be IDLE, DELAY, WND, GAP and FIN, one-hot encoded.
REQ-015 IDLE: START=1 at edge k latches all config inputs, sets BUSY at k, and enters DELAY; START is ignored in every other state.
REQ-016 The first ACQ_WND rise SHALL occur at edge k+FIRST_DELAY; FIRST_DELAY=0 is treated as 1.
REQ-017 WND: ACQ_WND SHALL stay high exactly WND_LEN_eff cycles, then GAP holds it low until the next rise.
REQ-018 The rising edges of windows n and n+1 SHALL be exactly ECHO_PERIOD_eff cycles apart.
REQ-019 WND_LEN_eff = max(WND_LEN,1); ECHO_PERIOD_eff = max(ECHO_PERIOD, WND_LEN_eff+1), guaranteeing at least one low cycle between windows.
REQ-020 ECHO_IDX SHALL be 0 at IDLE exit and increment on each window rise after the first.
REQ-021 After the last window falls, enter FIN; DONE=1 for exactly that one cycle, BUSY clears on the same edge, then return to IDLE.
REQ-022 NUM_ECHOES=0: no window is produced; the FSM SHALL go DELAY-bypassed straight to FIN, so DONE pulses at edge k+1.
REQ-023 Counters SHALL be down-counters on latched values; changes to inputs while BUSY have no effect.
REQ-024 START held high across FIN->IDLE SHALL start a new train on the first IDLE cycle (level-sensitive acceptance).
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 RESET=1 at any edge, including mid-train, SHALL force IDLE, ACQ_WND=0, BUSY=0, DONE=0, ECHO_IDX=0 and clear all counters and latched config.
REQ-027 RESET has priority over START at the same edge.

Configuration
REQ-028 With macro ACQ_WND_DUMMY_ECHO_EN defined, an input DUMMY_ECHOES (ECHO_CNT_WIDTH) SHALL be latched at START and windows for the first DUMMY_ECHOES echo slots suppressed (ACQ_WND held low, timing slots and ECHO_IDX still advance); total slots = DUMMY_ECHOES+NUM_ECHOES.
REQ-029 Without ACQ_WND_DUMMY_ECHO_EN, the DUMMY_ECHOES port SHALL not exist and every slot produces a window.

Structure
REQ-030 A shared package SHALL hold the state encoding constants and the default widths.
REQ-031 One sub-module, wnd_down_counter (loadable down-counter with zero flag), SHALL be instantiated for the delay/period and window-length timers.

Verification
REQ-032 FIRST_DELAY=5, ECHO_PERIOD=10, WND_LEN=4, NUM_ECHOES=3, START at edge 0 -> rises at 5,15,25; falls at 9,19,29; DONE at 30; ECHO_IDX 0,1,2.
REQ-033 WND_LEN=10, ECHO_PERIOD=10, NUM_ECHOES=2 -> period becomes 11, each window high 10 cycles, exactly one low cycle between windows.
REQ-034 NUM_ECHOES=0, START at edge 0 -> ACQ_WND never high, DONE at edge 1, BUSY high for one cycle only.
REQ-035 RESET at edge 17 during the REQ-032 train -> all outputs 0 at edge 17; with START low, no further activity.
REQ-036 START re-pulsed at edge 12 while BUSY -> ignored; waveform identical to REQ-032.
REQ-037 (ACQ_WND_DUMMY_ECHO_EN) DUMMY_ECHOES=2 with REQ-032 config -> first rise at edge 25; rises at 25,35,45; DONE at 50.
